// File: rtl/jzjpcc_memory_if.sv
// jzjpcc_writeback_if
//   Registered memory-stage to writeback-stage bundle.
//   memory    : driver side (memory stage owns the pipeline register)
//   writeback : receiver side
// Fields:
//   rdAddr        destination register index
//   rdWriteEnable register-file write enable (0 marks a bubble)
//   rdSource      writeback source select (0 ALU, 1 memory)
//   memoryOut     raw data word returned by the data memory (0 for non-loads)
//   aluResult     ALU result / effective address
//   funct3        load/store width code, used downstream for extraction
//   memByteMask   active byte lanes of the access (4'b1111 for non-memory)
interface jzjpcc_writeback_if;
  logic [4:0]  rdAddr;
  logic        rdWriteEnable;
  logic        rdSource;
  logic [31:0] memoryOut;
  logic [31:0] aluResult;
  logic [2:0]  funct3;
  logic [3:0]  memByteMask;

  modport memory (
    output rdAddr, rdWriteEnable, rdSource, memoryOut, aluResult, funct3, memByteMask
  );

  modport writeback (
    input rdAddr, rdWriteEnable, rdSource, memoryOut, aluResult, funct3, memByteMask
  );
endinterface

// File: rtl/jzjpcc_memory.sv
// jzjpcc_memory
//   Memory stage of the JZJ pipelined core. Turns execute-stage load/store
//   instructions into data-memory requests, stalls upstream until the memory
//   acknowledges, flags misaligned accesses and registers the result for
//   writeback. The data memory is big-endian in lane order (byte offset k
//   lives in lane 3-k), so store data is byte-swapped here and load data is
//   passed through raw for the writeback stage to extract.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   *_execute               instruction fields from the execute stage
//   dmemAddr/WriteData/ByteEnable/Req/We   request to the data memory
//   dmemAck, dmemReadData   completion strobe and raw read word
//   stall_memory            freezes upstream stages while a request is pending
//   misaligned_memory       one-cycle pulse for a misaligned access
//   badAddr_memory          address of the last misaligned access
//   writebackIF             registered bundle to the writeback stage
module jzjpcc_memory (
  input  logic        clock,
  input  logic        reset,

  input  logic        valid_execute,
  input  logic        memRead_execute,
  input  logic        memWrite_execute,
  input  logic [31:0] aluResult_execute,
  input  logic [31:0] rs2_execute,
  input  logic [2:0]  funct3_execute,
  input  logic [4:0]  rdAddr_execute,
  input  logic        rdWriteEnable_execute,
  input  logic        rdSource_execute,

  output logic [31:0] dmemAddr,
  output logic [31:0] dmemWriteData,
  output logic [3:0]  dmemByteEnable,
  output logic        dmemReq,
  output logic        dmemWe,
  input  logic        dmemAck,
  input  logic [31:0] dmemReadData,

  output logic        stall_memory,
  output logic        misaligned_memory,
  output logic [31:0] badAddr_memory,

  jzjpcc_writeback_if.memory writebackIF
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]  state;
  logic [0:0]  nextState;

  logic        access;
  logic        isStore;
  logic [1:0]  offset;
  logic [1:0]  width;
  logic        misaligned;
  logic        alignedAccess;
  logic [3:0]  byteMask;
  logic [31:0] storeData;
  logic        loadInstr;

  assign access        = valid_execute & (memRead_execute | memWrite_execute);
  // Both read and write high is illegal; the write wins.
  assign isStore       = memWrite_execute;
  assign offset        = aluResult_execute[1:0];
  assign width         = funct3_execute[1:0];
  assign misaligned    = access & (((width == 2'b01) & offset[0]) |
                                   (width[1] & (offset != 2'b00)));
  assign alignedAccess = access & ~misaligned;

  // Lane mask and lane-placed store data for the current instruction.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    byteMask  = 4'b1111;
    storeData = {rs2_execute[7:0], rs2_execute[15:8], rs2_execute[23:16], rs2_execute[31:24]};
    if (access) begin
      case (width)
        2'b00: begin
          byteMask  = 4'b1000 >> offset;
          storeData = {4{rs2_execute[7:0]}};
        end
        2'b01: begin
          byteMask  = offset[1] ? 4'b0011 : 4'b1100;
          storeData = {2{rs2_execute[7:0], rs2_execute[15:8]}};
        end
        default: ;
      endcase
    end
  end

  assign dmemAddr       = {aluResult_execute[31:2], 2'b00};
  assign dmemWriteData  = storeData;
  assign dmemByteEnable = byteMask;
  // Upstream is frozen while waiting, so the request fields stay stable
  // without a local copy.
  assign dmemWe         = dmemReq & isStore;

  // Request / stall control. Reset gates the combinational outputs so a
  // pending request is dropped in the reset cycle itself.
  always_comb begin
    nextState    = state;
    dmemReq      = 1'b0;
    stall_memory = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (alignedAccess) begin
            dmemReq = 1'b1;
            if (!dmemAck) begin
              stall_memory = 1'b1;
              nextState    = WAIT;
            end
          end
        end
        WAIT: begin
          dmemReq      = 1'b1;
          stall_memory = ~dmemAck;
          if (dmemAck) nextState = IDLE;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // A real instruction reaches writeback only when it is not stalled and not
  // faulting; everything else becomes a zeroed bubble.
  assign loadInstr = valid_execute & ~stall_memory & ~misaligned;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                     <= IDLE;
      misaligned_memory         <= 1'b0;
      badAddr_memory            <= '0;
      writebackIF.rdAddr        <= '0;
      writebackIF.rdWriteEnable <= 1'b0;
      writebackIF.rdSource      <= 1'b0;
      writebackIF.memoryOut     <= '0;
      writebackIF.aluResult     <= '0;
      writebackIF.funct3        <= '0;
      writebackIF.memByteMask   <= '0;
    end else begin
      state             <= nextState;
      misaligned_memory <= misaligned;
      if (misaligned) badAddr_memory <= aluResult_execute;

      if (loadInstr) begin
        writebackIF.rdAddr        <= rdAddr_execute;
        writebackIF.rdWriteEnable <= rdWriteEnable_execute;
        writebackIF.rdSource      <= rdSource_execute;
        writebackIF.memoryOut     <= (access & ~isStore) ? dmemReadData : 32'h0;
        writebackIF.aluResult     <= aluResult_execute;
        writebackIF.funct3        <= funct3_execute;
        writebackIF.memByteMask   <= byteMask;
      end else begin
        writebackIF.rdAddr        <= '0;
        writebackIF.rdWriteEnable <= 1'b0;
        writebackIF.rdSource      <= 1'b0;
        writebackIF.memoryOut     <= '0;
        writebackIF.aluResult     <= '0;
        writebackIF.funct3        <= '0;
        writebackIF.memByteMask   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jzjpcc_memory.sv
// Testbench for jzjpcc_memory. Stimulus pushes per-cycle expectations for the
// memory request side and for the writeback register into two queues; a
// negedge monitor pops and compares them against the DUT outputs.
module tb_jzjpcc_memory;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        stall;
  } combExp_t;

  typedef struct {
    logic [4:0]  rdAddr;
    logic        rdWe;
    logic        rdSrc;
    logic [31:0] memOut;
    logic [31:0] alu;
    logic [2:0]  f3;
    logic [3:0]  mask;
    logic        mis;
    logic        chkBad;
    logic [31:0] bad;
  } regExp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_execute, memRead_execute, memWrite_execute;
  logic [31:0] aluResult_execute, rs2_execute;
  logic [2:0]  funct3_execute;
  logic [4:0]  rdAddr_execute;
  logic        rdWriteEnable_execute, rdSource_execute;
  logic [31:0] dmemAddr, dmemWriteData, dmemReadData;
  logic [3:0]  dmemByteEnable;
  logic        dmemReq, dmemWe, dmemAck;
  logic        stall_memory, misaligned_memory;
  logic [31:0] badAddr_memory;

  jzjpcc_writeback_if wbIf ();

  jzjpcc_memory dut (
    .clock                 (clock),
    .reset                 (reset),
    .valid_execute         (valid_execute),
    .memRead_execute       (memRead_execute),
    .memWrite_execute      (memWrite_execute),
    .aluResult_execute     (aluResult_execute),
    .rs2_execute           (rs2_execute),
    .funct3_execute        (funct3_execute),
    .rdAddr_execute        (rdAddr_execute),
    .rdWriteEnable_execute (rdWriteEnable_execute),
    .rdSource_execute      (rdSource_execute),
    .dmemAddr              (dmemAddr),
    .dmemWriteData         (dmemWriteData),
    .dmemByteEnable        (dmemByteEnable),
    .dmemReq               (dmemReq),
    .dmemWe                (dmemWe),
    .dmemAck               (dmemAck),
    .dmemReadData          (dmemReadData),
    .stall_memory          (stall_memory),
    .misaligned_memory     (misaligned_memory),
    .badAddr_memory        (badAddr_memory),
    .writebackIF           (wbIf)
  );

  always #5 clock = ~clock;

  combExp_t combQ[$];
  regExp_t  regQ[$];
  int       checks = 0;
  int       errors = 0;
  logic     monOn  = 1'b0;
  combExp_t cItem;
  regExp_t  rItem;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic combExp_t cx(input logic req, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be, input logic stall);
    combExp_t c;
    c.req = req; c.we = we; c.addr = addr; c.wdata = wdata; c.be = be; c.stall = stall;
    return c;
  endfunction

  function automatic regExp_t rx(input logic [4:0] rd, input logic we, input logic src,
                                 input logic [31:0] mo, input logic [31:0] alu,
                                 input logic [2:0] f3, input logic [3:0] mask);
    regExp_t r;
    r.rdAddr = rd; r.rdWe = we; r.rdSrc = src; r.memOut = mo; r.alu = alu;
    r.f3 = f3; r.mask = mask; r.mis = 1'b0; r.chkBad = 1'b0; r.bad = '0;
    return r;
  endfunction

  function automatic regExp_t bubble();
    return rx(5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 4'b0000);
  endfunction

  function automatic regExp_t misBubble(input logic [31:0] bad);
    regExp_t r;
    r = bubble();
    r.mis = 1'b1; r.chkBad = 1'b1; r.bad = bad;
    return r;
  endfunction

  function automatic regExp_t resetRec();
    regExp_t r;
    r = bubble();
    r.chkBad = 1'b1;
    return r;
  endfunction

  function automatic combExp_t idleBus();
    return cx(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0);
  endfunction

  task automatic setIn(input logic v, input logic rd, input logic wr, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [2:0] f3, input logic [4:0] rdA,
                       input logic rdWe, input logic rdSrc, input logic ack, input logic [31:0] rdata);
    valid_execute = v; memRead_execute = rd; memWrite_execute = wr;
    aluResult_execute = alu; rs2_execute = rs2; funct3_execute = f3;
    rdAddr_execute = rdA; rdWriteEnable_execute = rdWe; rdSource_execute = rdSrc;
    dmemAck = ack; dmemReadData = rdata;
  endtask

  task automatic tick(input combExp_t c, input regExp_t r);
    combQ.push_back(c);
    regQ.push_back(r);
    @(posedge clock);
    #1;
  endtask

  // Monitor: combinational request side reflects the current cycle; the
  // writeback register reflects the previous edge.
  always @(negedge clock) begin
    if (monOn) begin
      if (combQ.size() != 0) begin
        cItem = combQ.pop_front();
        check("dmemReq", 32'(dmemReq), 32'(cItem.req));
        check("stall_memory", 32'(stall_memory), 32'(cItem.stall));
        if (cItem.req) begin
          check("dmemAddr", dmemAddr, cItem.addr);
          check("dmemByteEnable", 32'(dmemByteEnable), 32'(cItem.be));
          check("dmemWe", 32'(dmemWe), 32'(cItem.we));
          if (cItem.we) check("dmemWriteData", dmemWriteData, cItem.wdata);
        end
      end
      if (regQ.size() != 0) begin
        rItem = regQ.pop_front();
        check("wb.rdAddr", 32'(wbIf.rdAddr), 32'(rItem.rdAddr));
        check("wb.rdWriteEnable", 32'(wbIf.rdWriteEnable), 32'(rItem.rdWe));
        check("wb.rdSource", 32'(wbIf.rdSource), 32'(rItem.rdSrc));
        check("wb.memoryOut", wbIf.memoryOut, rItem.memOut);
        check("wb.aluResult", wbIf.aluResult, rItem.alu);
        check("wb.funct3", 32'(wbIf.funct3), 32'(rItem.f3));
        check("wb.memByteMask", 32'(wbIf.memByteMask), 32'(rItem.mask));
        check("misaligned_memory", 32'(misaligned_memory), 32'(rItem.mis));
        if (rItem.chkBad) check("badAddr_memory", badAddr_memory, rItem.bad);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    setIn(0, 0, 0, 32'h0, 32'h0, 3'b000, 5'd0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    regQ.push_back(resetRec());
    monOn = 1'b1;
    reset = 1'b0;

    // lb 0x102, same-cycle ack
    setIn(1, 1, 0, 32'h102, 32'h0, 3'b000, 5'd5, 1, 1, 1, 32'hAABBCCDD);
    tick(cx(1, 0, 32'h100, 32'h0, 4'b0010, 0), rx(5'd5, 1, 1, 32'hAABBCCDD, 32'h102, 3'b000, 4'b0010));

    // sh 0x1234 to 0x200
    setIn(1, 0, 1, 32'h200, 32'h00001234, 3'b001, 5'd0, 0, 0, 1, 32'hDEADBEEF);
    tick(cx(1, 1, 32'h200, 32'h34123412, 4'b1100, 0), rx(5'd0, 0, 0, 32'h0, 32'h200, 3'b001, 4'b1100));

    // lw 0x40, ack delayed three cycles
    setIn(1, 1, 0, 32'h40, 32'h0, 3'b010, 5'd9, 1, 1, 0, 32'h0);
    tick(cx(1, 0, 32'h40, 32'h0, 4'b1111, 1), bubble());
    tick(cx(1, 0, 32'h40, 32'h0, 4'b1111, 1), bubble());
    tick(cx(1, 0, 32'h40, 32'h0, 4'b1111, 1), bubble());
    dmemAck = 1'b1; dmemReadData = 32'h11223344;
    tick(cx(1, 0, 32'h40, 32'h0, 4'b1111, 0), rx(5'd9, 1, 1, 32'h11223344, 32'h40, 3'b010, 4'b1111));

    // lh 0x101 misaligned; the stray ack must be ignored
    setIn(1, 1, 0, 32'h101, 32'h0, 3'b001, 5'd3, 1, 1, 1, 32'h99999999);
    tick(idleBus(), misBubble(32'h101));

    // ALU add result 5 into x7, then lw 0x8 with ack
    setIn(1, 0, 0, 32'h5, 32'h0, 3'b000, 5'd7, 1, 0, 0, 32'h0);
    tick(idleBus(), rx(5'd7, 1, 0, 32'h0, 32'h5, 3'b000, 4'b1111));
    setIn(1, 1, 0, 32'h8, 32'h0, 3'b010, 5'd8, 1, 1, 1, 32'hCAFEF00D);
    tick(cx(1, 0, 32'h8, 32'h0, 4'b1111, 0), rx(5'd8, 1, 1, 32'hCAFEF00D, 32'h8, 3'b010, 4'b1111));

    // invalid slot with a stray ack
    setIn(0, 0, 0, 32'h0, 32'h0, 3'b000, 5'd0, 0, 0, 1, 32'h12121212);
    tick(idleBus(), bubble());

    // back-to-back stores: sb 0x303, sw 0x304, read+write treated as sb 0x401
    setIn(1, 0, 1, 32'h303, 32'h000000A5, 3'b000, 5'd0, 0, 0, 1, 32'h0);
    tick(cx(1, 1, 32'h300, 32'hA5A5A5A5, 4'b0001, 0), rx(5'd0, 0, 0, 32'h0, 32'h303, 3'b000, 4'b0001));
    setIn(1, 0, 1, 32'h304, 32'h12345678, 3'b010, 5'd0, 0, 0, 1, 32'h0);
    tick(cx(1, 1, 32'h304, 32'h78563412, 4'b1111, 0), rx(5'd0, 0, 0, 32'h0, 32'h304, 3'b010, 4'b1111));
    setIn(1, 1, 1, 32'h401, 32'h000000C3, 3'b000, 5'd0, 0, 0, 1, 32'hFFFFFFFF);
    tick(cx(1, 1, 32'h400, 32'hC3C3C3C3, 4'b0100, 0), rx(5'd0, 0, 0, 32'h0, 32'h401, 3'b000, 4'b0100));

    // lbu 0x3, lhu 0x2
    setIn(1, 1, 0, 32'h3, 32'h0, 3'b100, 5'd4, 1, 1, 1, 32'h01020304);
    tick(cx(1, 0, 32'h0, 32'h0, 4'b0001, 0), rx(5'd4, 1, 1, 32'h01020304, 32'h3, 3'b100, 4'b0001));
    setIn(1, 1, 0, 32'h2, 32'h0, 3'b101, 5'd6, 1, 1, 1, 32'h0A0B0C0D);
    tick(cx(1, 0, 32'h0, 32'h0, 4'b0011, 0), rx(5'd6, 1, 1, 32'h0A0B0C0D, 32'h2, 3'b101, 4'b0011));

    // sw 0x106 misaligned
    setIn(1, 0, 1, 32'h106, 32'hFFFF0000, 3'b010, 5'd0, 0, 0, 0, 32'h0);
    tick(idleBus(), misBubble(32'h106));

    // lw 0x80 stalls, reset lands in WAIT
    setIn(1, 1, 0, 32'h80, 32'h0, 3'b010, 5'd2, 1, 1, 0, 32'h0);
    tick(cx(1, 0, 32'h80, 32'h0, 4'b1111, 1), bubble());
    tick(cx(1, 0, 32'h80, 32'h0, 4'b1111, 1), bubble());
    reset = 1'b1;
    tick(idleBus(), resetRec());
    reset = 1'b0;
    setIn(0, 0, 0, 32'h0, 32'h0, 3'b000, 5'd0, 0, 0, 0, 32'h0);
    tick(idleBus(), bubble());
    dmemAck = 1'b1; dmemReadData = 32'h77777777;
    tick(idleBus(), bubble());
    dmemAck = 1'b0;
    tick(idleBus(), bubble());

    // normal single-cycle load after the abandoned request
    setIn(1, 1, 0, 32'hC, 32'h0, 3'b010, 5'd1, 1, 1, 1, 32'h55AA55AA);
    tick(cx(1, 0, 32'hC, 32'h0, 4'b1111, 0), rx(5'd1, 1, 1, 32'h55AA55AA, 32'hC, 3'b010, 4'b1111));
    setIn(0, 0, 0, 32'h0, 32'h0, 3'b000, 5'd0, 0, 0, 0, 32'h0);
    tick(idleBus(), bubble());

    @(negedge clock);
    #1;
    monOn = 1'b0;
    check("combQ drained", 32'(combQ.size()), 32'd0);
    check("regQ drained", 32'(regQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jzjpcc_memory.md
JZJPCC_MEMORY -- requirements
Module: jzjpcc_memory

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named as the codebase does: clock, reset.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 valid_execute  in  1  execute-stage instruction valid.
REQ-005 memRead_execute, memWrite_execute  in  1 each  load / store instruction; both high is illegal and SHALL be treated as a store.
REQ-006 aluResult_execute  in  32  effective address, or the ALU result for non-memory instructions.
REQ-007 rs2_execute  in  32  store data.
REQ-008 funct3_execute  in  3  load/store width code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-009 rdAddr_execute  in  5; rdWriteEnable_execute  in  1; rdSource_execute  in  1  destination register, write enable and writeback source select (0 ALU, 1 memory).
REQ-010 dmemAddr  out  32  word address, {aluResult_execute[31:2], 2'b00}.
REQ-011 dmemWriteData  out  32  lane-placed store data.
REQ-012 dmemByteEnable  out  4  active lanes.
REQ-013 dmemReq  out  1; dmemWe  out  1  request strobe and write qualifier.
REQ-014 dmemAck  in  1; dmemReadData  in  32  completion strobe and raw read word.
REQ-015 stall_memory  out  1  freezes upstream stages; upstream inputs SHALL be held stable while it is high.
REQ-016 misaligned_memory  out  1; badAddr_memory  out  32  one-cycle misaligned-access pulse and the offending address.
REQ-017 writebackIF  jzjpcc_writeback_if.memory modport SHALL carry rdAddr, rdWriteEnable, rdSource, memoryOut, aluResult, funct3 and memByteMask, all registered.

Function
REQ-018 access = valid_execute & (memRead_execute | memWrite_execute).
REQ-019 Byte lane for address offset k SHALL be lane 3-k: offset 0 -> 4'b1000, 1 -> 0100, 2 -> 0010, 3 -> 0001.
REQ-020 Halfword lanes: offset 0 -> 4'b1100, offset 2 -> 4'b0011.
REQ-021 Word lanes: 4'b1111.
REQ-022 Non-memory instructions SHALL produce a mask of 4'b1111.
REQ-023 Misaligned access is a halfword with addr[0]=1, or a word with addr[1:0]!=0.
REQ-024 Store data byte: {4{rs2[7:0]}}.
REQ-025 Store data halfword: {2{rs2[7:0],rs2[15:8]}}.
REQ-026 Store data word: byte-swapped rs2, i.e. {rs2[7:0],rs2[15:8],rs2[23:16],rs2[31:24]}.
REQ-027 The FSM SHALL have states IDLE and WAIT.
REQ-028 IDLE with an aligned access: dmemReq=1 combinationally and dmemWe=memWrite_execute.
REQ-029 IDLE, aligned access, dmemAck in the same cycle: complete, stay in IDLE, stall_memory=0.
REQ-030 IDLE, aligned access, dmemAck=0: stall_memory=1 and go to WAIT.
REQ-031 WAIT: dmemReq=1 and address, data, mask and we held unchanged; stall_memory=!dmemAck; dmemAck returns to IDLE.
REQ-032 On completion the writeback register SHALL load rdAddr, rdWriteEnable, rdSource, funct3, mask, aluResult, and memoryOut=dmemReadData (raw, no swap); a store loads memoryOut=0.
REQ-033 Non-memory valid instruction: the register SHALL load at the next edge with zero latency, memoryOut=0 and no request.
REQ-034 Any cycle with stall_memory=1, or with valid_execute=0, SHALL load a bubble: rdWriteEnable=0, other fields don't-care-zero.
REQ-035 Misaligned access: no dmemReq, load a bubble, assert misaligned_memory for exactly one cycle with badAddr_memory=aluResult_execute, and no stall.
REQ-036 dmemAck while not requesting SHALL be ignored.
REQ-037 Back-to-back accesses SHALL each receive their own request, so a 1-cycle-ack memory sustains one access per cycle.

Reset
REQ-038 Reset SHALL force the FSM to IDLE and deassert dmemReq, stall_memory and misaligned_memory.
REQ-039 Reset SHALL clear all writebackIF fields, badAddr_memory and all other registered state to 0.
REQ-040 Reset during WAIT SHALL abandon the request without writing back; a later dmemAck SHALL be ignored per REQ-036.

Verification
REQ-041 lb from addr 0x102 with readData 0xAABBCCDD and same-cycle ack: mask 4'b0010, memoryOut 0xAABBCCDD, funct3 000, rdWriteEnable=1 next cycle, stall never high.
REQ-042 sh of rs2=0x00001234 to 0x200: byteEnable 4'b1100, writeData 0x34123412, dmemWe=1, next-cycle rdWriteEnable=0.
REQ-043 lw from 0x40 with ack delayed 3 cycles: dmemReq high for 4 cycles, stall_memory high for 3, writeback register bubbles for 3 cycles and then loads the load's fields with rdWriteEnable=1.
REQ-044 lh at 0x101: no dmemReq, misaligned_memory pulses 1 cycle with badAddr 0x101, bubble written.
REQ-045 Reset asserted in WAIT: next cycle dmemReq=0, stall_memory=0, rdWriteEnable=0; ack 2 cycles later has no effect.
REQ-046 ALU add with result 0x5, rd=7, followed by lw at 0x8 with 1-cycle ack: consecutive cycles show aluResult 0x5 (rdSource 0, mask 1111) then the lw fields, with no stall.
